// File: rtl/imem_boot_loader.sv
// Boot-time program loader: assembles a little-endian byte stream (LEN, DATA words, CSUM) into
// IMEM writes and releases the core from reset only after the checksum matches.
module imem_boot_loader #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  output logic              s_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_rst_n,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   word_cnt
);

  localparam logic [32:0]     MaxWords = 33'd1 << ADDR_W;
  localparam logic [ADDR_W:0] CntOne   = {{ADDR_W{1'b0}}, 1'b1};

  typedef enum logic [2:0] {StLen, StData, StCsum, StDone, StErr} state_e;

  state_e            state_q;
  logic [1:0]        idx_q;
  logic [23:0]       asm_q;
  logic [31:0]       sum_q;
  logic [ADDR_W:0]   cnt_q;
  logic [ADDR_W:0]   len_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              core_rst_n_q;
  logic              done_q;
  logic              err_q;

  logic        accept;
  logic        last_byte;
  logic [31:0] word;

  always_comb begin
    s_ready   = (state_q == StLen) || (state_q == StData) || (state_q == StCsum);
    accept    = s_valid && s_ready;
    last_byte = accept && (idx_q == 2'd3);
    // The 4th byte is used straight off the bus so the word completes on its accept edge.
    word      = {s_data, asm_q};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StLen;
      idx_q        <= 2'd0;
      asm_q        <= 24'd0;
      sum_q        <= 32'd0;
      cnt_q        <= '0;
      len_q        <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= 32'd0;
      core_rst_n_q <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      we_q <= 1'b0;
      if (accept) begin
        idx_q <= idx_q + 2'd1;
        case (idx_q)
          2'd0:    asm_q[7:0]   <= s_data;
          2'd1:    asm_q[15:8]  <= s_data;
          2'd2:    asm_q[23:16] <= s_data;
          default: ;
        endcase
      end
      if (last_byte) begin
        case (state_q)
          StLen: begin
            if ((word == 32'd0) || ({1'b0, word} > MaxWords)) begin
              state_q <= StErr;
              err_q   <= 1'b1;
            end else begin
              len_q   <= word[ADDR_W:0];
              state_q <= StData;
            end
          end
          StData: begin
            we_q    <= 1'b1;
            addr_q  <= cnt_q[ADDR_W-1:0];
            wdata_q <= word;
            cnt_q   <= cnt_q + CntOne;
            sum_q   <= sum_q + word;
            if ((cnt_q + CntOne) == len_q) state_q <= StCsum;
          end
          StCsum: begin
            if (word == sum_q) begin
              state_q      <= StDone;
              done_q       <= 1'b1;
              core_rst_n_q <= 1'b1;
            end else begin
              state_q <= StErr;
              err_q   <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign core_rst_n = core_rst_n_q;
  assign load_done  = done_q;
  assign load_err   = err_q;
  assign word_cnt   = cnt_q;

endmodule
